// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | uart_pkg : state encoding, parity constants and frame width  |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic ptype);
    return (^data) ^ (ptype == PARITY_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------+
// | uart_rx_sampler : per-bit clock counter, strobes, bit value  |
// | Option: UART_RX_MAJORITY_EN (2-of-3 vote)  Rev 1.0           |
// +--------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_start,
  input  logic i_rx,
  output logic o_decision,
  output logic o_wrap,
  output logic o_bit
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_start || !i_run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign o_decision = i_run && (cnt_q == CNT_DEC);
  assign o_wrap     = i_run && (cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_PRE = CW'(H - 1);

  logic vote0_q, vote0_d;
  logic vote1_q, vote1_d;

  always_comb begin
    vote0_d = vote0_q;
    vote1_d = vote1_q;
    if (i_run && (cnt_q == CNT_PRE)) vote0_d = i_rx;
    if (i_run && (cnt_q == CNT_MID)) vote1_d = i_rx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      vote0_q <= vote0_d;
      vote1_q <= vote1_d;
    end
  end

  // Third vote is the live sample taken at the decision count itself.
  assign o_bit = (vote0_q & vote1_q) | (vote0_q & i_rx) | (vote1_q & i_rx);
`else
  logic samp_q, samp_d;

  always_comb begin
    samp_d = samp_q;
    if (i_run && (cnt_q == CNT_MID)) samp_d = i_rx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      samp_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      samp_q <= samp_d;
    end
  end

  assign o_bit = samp_q;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------+
// | uart_rx : 8-bit UART receiver, optional parity, status flags |
// | Option: UART_RX_MAJORITY_EN (sampler vote)  Rev 1.0          |
// +--------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_serial_data,
  input  logic              i_parity_enable,
  input  logic              i_parity_type,
  output logic [DATA_W-1:0] o_p_data,
  output logic              o_data_valid,
  output logic              o_parity_error,
  output logic              o_stop_error,
  output logic              o_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  logic sync1_q, rx_s_q, rx_d_q;
  logic start_edge;

  rx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              par_flag_q, par_flag_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              parity_error_q, parity_error_d;
  logic              stop_error_q, stop_error_d;
  logic              data_valid_q, data_valid_d;

  logic run, start, decision, wrap, rx_bit;

  assign start_edge = rx_d_q & ~rx_s_q;
  assign run        = (state_q != ST_IDLE);
  assign start      = (state_q == ST_IDLE) && start_edge;

  uart_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_sampler (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (run),
    .i_start    (start),
    .i_rx       (rx_s_q),
    .o_decision (decision),
    .o_wrap     (wrap),
    .o_bit      (rx_bit)
  );

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_en_d       = par_en_q;
    par_odd_d      = par_odd_q;
    par_flag_d     = par_flag_q;
    p_data_d       = p_data_q;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    data_valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          bit_cnt_d  = '0;
          par_en_d   = i_parity_enable;
          par_odd_d  = i_parity_type;
          par_flag_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (decision && rx_bit) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decision) shift_d = {rx_bit, shift_q[DATA_W-1:1]};
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (decision && (rx_bit != calc_parity(shift_q, par_odd_q))) par_flag_d = 1'b1;
        if (wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave at the decision point so a start edge in the second half of
        // the stop bit is still caught.
        if (decision) begin
          p_data_d       = shift_q;
          parity_error_d = par_flag_q;
          stop_error_d   = ~rx_bit;
          data_valid_d   = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q        <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_d_q         <= 1'b1;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_odd_q      <= 1'b0;
      par_flag_q     <= 1'b0;
      p_data_q       <= '0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      data_valid_q   <= 1'b0;
    end else begin
      sync1_q        <= i_serial_data;
      rx_s_q         <= sync1_q;
      rx_d_q         <= rx_s_q;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_odd_q      <= par_odd_d;
      par_flag_q     <= par_flag_d;
      p_data_q       <= p_data_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      data_valid_q   <= data_valid_d;
    end
  end

  assign o_p_data       = p_data_q;
  assign o_data_valid   = data_valid_q;
  assign o_parity_error = parity_error_q;
  assign o_stop_error   = stop_error_q;
  assign o_busy         = run;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_uart_rx : directed table-driven bench for uart_rx         |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_uart_rx;

  localparam int C = 8;
  localparam int H = C / 2;

  logic       i_clk;
  logic       i_rst;
  logic       i_serial_data;
  logic       i_parity_enable;
  logic       i_parity_type;
  logic [7:0] o_p_data;
  logic       o_data_valid;
  logic       o_parity_error;
  logic       o_stop_error;
  logic       o_busy;

  uart_rx #(
    .CLKS_PER_BIT (C)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_serial_data   (i_serial_data),
    .i_parity_enable (i_parity_enable),
    .i_parity_type   (i_parity_type),
    .o_p_data        (o_p_data),
    .o_data_valid    (o_data_valid),
    .o_parity_error  (o_parity_error),
    .o_stop_error    (o_stop_error),
    .o_busy          (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int         checks = 0;
  int         errors = 0;
  int         vcount = 0;
  logic [7:0] cap_data;
  logic       cap_perr;
  logic       cap_serr;
  logic       busy_seen;

  always @(negedge i_clk) begin
    if (o_data_valid) begin
      vcount   = vcount + 1;
      cap_data = o_p_data;
      cap_perr = o_parity_error;
      cap_serr = o_stop_error;
    end
    if (o_busy) busy_seen = 1'b1;
  end

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_type;
    logic       par_bit;
    logic       stop_bit;
    logic       scramble;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One serial bit lasting C clocks; optional one-clock low spike mid-bit.
  task automatic drive_bit(input logic b, input logic spike);
    for (int k = 0; k < C; k++) begin
      i_serial_data = (spike && (k == H + 1)) ? 1'b0 : b;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input logic scramble, input int spike_bit);
    drive_bit(1'b0, 1'b0);
    if (scramble) begin
      i_parity_enable = ~i_parity_enable;
      i_parity_type   = ~i_parity_type;
    end
    for (int b = 0; b < 8; b++) drive_bit(d[b], (b == spike_bit));
    if (pen) drive_bit(pbit, 1'b0);
    drive_bit(sbit, 1'b0);
  endtask

  initial begin
    int base;
    logic [7:0] spike_exp;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'hE1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0, 1'b1};

    i_rst = 1'b1;
    i_serial_data = 1'b0;
    i_parity_enable = 1'b0;
    i_parity_type = 1'b0;
    busy_seen = 1'b0;
    idle(2);
    chk("reset_data", o_p_data, 8'h00);
    chk("reset_valid", o_data_valid, 1'b0);
    chk("reset_perr", o_parity_error, 1'b0);
    chk("reset_serr", o_stop_error, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    i_serial_data = 1'b1;
    tick();
    i_rst = 1'b0;
    idle(2 * C);
    chk("reset_no_valid", vcount, 0);

    for (int i = 0; i < 8; i++) begin
      base = vcount;
      i_parity_enable = vecs[i].par_en;
      i_parity_type   = vecs[i].par_type;
      send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_bit,
                 vecs[i].stop_bit, vecs[i].scramble, -1);
      i_serial_data = 1'b1;
      idle(2 * C);
      chk($sformatf("v%0d_count", i), vcount - base, 1);
      chk($sformatf("v%0d_data", i), cap_data, vecs[i].exp_data);
      chk($sformatf("v%0d_perr", i), cap_perr, vecs[i].exp_perr);
      chk($sformatf("v%0d_serr", i), cap_serr, vecs[i].exp_serr);
      chk($sformatf("v%0d_hold", i), o_p_data, vecs[i].exp_data);
      chk($sformatf("v%0d_busy", i), o_busy, 1'b0);
    end

    // Stop bit low and line left low: one frame, then silence.
    base = vcount;
    i_parity_enable = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(4 * C);
    chk("brk_count", vcount - base, 1);
    chk("brk_data", cap_data, 8'h3C);
    chk("brk_serr", cap_serr, 1'b1);
    chk("brk_busy", o_busy, 1'b0);
    i_serial_data = 1'b1;
    idle(2 * C);
    chk("brk_silent", vcount - base, 1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(2 * C);
    chk("brk_recover_count", vcount - base, 2);
    chk("brk_recover_data", cap_data, 8'h81);
    chk("brk_recover_serr", cap_serr, 1'b0);

    // Two-clock glitch in idle: false start.
    base = vcount;
    busy_seen = 1'b0;
    i_serial_data = 1'b0;
    idle(2);
    i_serial_data = 1'b1;
    idle(2 * C);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_busy", o_busy, 1'b0);
    chk("glitch_no_valid", vcount - base, 0);

    // One-clock spike at the mid-bit sample of data bit 2.
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 8'hFF;
`else
    spike_exp = 8'hFB;
`endif
    base = vcount;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    i_serial_data = 1'b1;
    idle(2 * C);
    chk("spike_count", vcount - base, 1);
    chk("spike_data", cap_data, spike_exp);

    // Back-to-back frames, reset in the middle of the second.
    base = vcount;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    drive_bit(1'b0, 1'b0);
    for (int b = 0; b < 4; b++) drive_bit(b[0], 1'b0);
    i_rst = 1'b1;
    i_serial_data = 1'b1;
    idle(2);
    i_rst = 1'b0;
    idle(2 * C);
    chk("b2b_count", vcount - base, 1);
    chk("b2b_first", cap_data, 8'h55);
    chk("b2b_abort_busy", o_busy, 1'b0);
    chk("b2b_abort_data", o_p_data, 8'h00);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    i_serial_data = 1'b1;
    idle(2 * C);
    chk("b2b_third_count", vcount - base, 2);
    chk("b2b_third_data", cap_data, 8'h0F);
    chk("b2b_third_perr", cap_perr, 1'b0);
    chk("b2b_third_serr", cap_serr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
